// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        S_OP,
        S_A,
        S_B,
        S_EXEC,
        S_OUT
    } state_e;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_DIV = 4'd2;
    localparam logic [3:0] OP_MOD = 4'd3;
    localparam logic [3:0] OP_SQR = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;

    localparam int unsigned SETTLE_MIN = 1;
    localparam int unsigned SETTLE_MAX = 15;
    localparam int unsigned CNT_W      = $clog2(SETTLE_MAX + 1);

endpackage

// File: rtl/alu_sequencer.sv
// Collects opcode/A/B bytes, drives an external ALU, waits SETTLE_CYCLES, returns the result.
// Optional divide/modulus-by-zero flagging is enabled by defining ALU_SEQ_DIVZERO_CHECK_EN.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_op,
    input  logic [15:0] alu_result,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_err,
    input  logic        out_ready,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_e            state_q;
    logic [7:0]        a_q;
    logic [7:0]        b_q;
    logic [3:0]        op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [15:0]       data_q;
    logic              valid_q;
    logic              unused_opcode_hi;

    assign unused_opcode_hi = ^in_data[7:4];

`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    logic err_q;
    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_OP;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_OP: if (in_valid) begin
                    op_q    <= in_data[3:0];
                    state_q <= S_A;
                end
                S_A: if (in_valid) begin
                    a_q     <= in_data;
                    state_q <= S_B;
                end
                S_B: if (in_valid) begin
                    b_q     <= in_data;
                    cnt_q   <= '0;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (cnt_q == CNT_LAST) begin
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
                        if ((op_q == OP_DIV || op_q == OP_MOD) && b_q == '0) begin
                            data_q <= '0;
                            err_q  <= 1'b1;
                        end else begin
                            data_q <= alu_result;
                            err_q  <= 1'b0;
                        end
`else
                        data_q <= alu_result;
`endif
                        valid_q <= 1'b1;
                        state_q <= S_OUT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_OUT: if (out_ready) begin
                    valid_q <= 1'b0;
                    state_q <= S_OP;
                end
                default: state_q <= S_OP;
            endcase
        end
    end

    // Handshake flags decode directly from the registered state.
    assign in_ready  = (state_q == S_OP) || (state_q == S_A) || (state_q == S_B);
    assign busy      = (state_q != S_OP);
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU beside the DUT.
module tb_alu_sequencer;

    localparam int unsigned SETTLE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_result;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_err;
    logic        out_ready = 1'b0;
    logic        busy;

    int unsigned total = 0;
    int unsigned passed = 0;
    logic [16:0] sb_q[$];
    bit          rand_ready = 1'b0;

    alu_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_err    (out_err),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] x;
        logic [15:0] y;
        x = {8'h00, a};
        y = {8'h00, b};
        case (op)
            4'd0: return x + y;
            4'd1: return x - y;
            4'd2: return (b == 8'h00) ? 16'hFFFF : x / y;
            4'd3: return (b == 8'h00) ? 16'hFFFF : x % y;
            4'd4: return x * x;
            4'd5: return x & y;
            4'd6: return x | y;
            4'd7: return {8'h00, ~a};
            default: return 16'h0000;
        endcase
    endfunction

    assign alu_result = ref_alu(alu_op, alu_a, alu_b);

    function automatic logic [16:0] expect_out(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
        if ((op == 4'd2 || op == 4'd3) && b == 8'h00) return {1'b1, 16'h0000};
`endif
        return {1'b0, ref_alu(op, a, b)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Entry and exit are at posedge+1.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int unsigned t;
        for (int unsigned g = 0; g < gap; g++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'hEE;
    endtask

    task automatic send_txn(input logic [7:0] opb, input logic [7:0] a, input logic [7:0] b,
                            input logic [16:0] exp, input int unsigned maxgap);
        sb_q.push_back(exp);
        send_byte(opb, $urandom_range(0, maxgap));
        send_byte(a,   $urandom_range(0, maxgap));
        send_byte(b,   $urandom_range(0, maxgap));
    endtask

    task automatic wait_out_valid(output int unsigned n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) chk("out_valid_wait", 32'(out_valid), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_alu_a"},     32'(alu_a),     32'd0);
        chk({tag, "_alu_b"},     32'(alu_b),     32'd0);
        chk({tag, "_alu_op"},    32'(alu_op),    32'd0);
        chk({tag, "_out_data"},  32'(out_data),  32'd0);
        chk({tag, "_out_err"},   32'(out_err),   32'd0);
    endtask

    // Monitor: pops one expectation per accepted result.
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_result", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e[15:0]));
                    chk("out_err",  32'(out_err),  32'(e[16]));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int unsigned n;
        logic [15:0] d0;
        logic        e0;
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;

        #1;
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;

        // Add, with latency measured from the B acceptance edge.
        send_txn(8'h00, 8'h12, 8'h34, {1'b0, 16'h0046}, 0);
        chk("exec_busy",     32'(busy),     32'd1);
        chk("exec_in_ready", 32'(in_ready), 32'd0);
        wait_out_valid(n);
        chk("latency", n, SETTLE);
        @(posedge clk); #1;

        send_txn(8'h01, 8'h05, 8'h07, {1'b0, 16'hFFFE}, 2);
        wait_out_valid(n);
        @(posedge clk); #1;

        sb_q.push_back({1'b0, 16'h0009});
        send_byte(8'hF4, 0);
        chk("opcode_high_nibble_ignored", 32'(alu_op), 32'd4);
        send_byte(8'h03, 1);
        send_byte(8'h55, 0);
        wait_out_valid(n);
        @(posedge clk); #1;

        // Consumer stall with a competing input byte on offer.
        out_ready = 1'b0;
        send_txn(8'h05, 8'h0F, 8'h3C, {1'b0, 16'h000C}, 0);
        wait_out_valid(n);
        d0 = out_data;
        e0 = out_err;
        in_valid = 1'b1;
        in_data  = 8'h77;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_data",  32'(out_data),  32'(d0));
            chk("stall_out_err",   32'(out_err),   32'(e0));
            chk("stall_in_ready",  32'(in_ready),  32'd0);
        end
        chk("stall_alu_op_held", 32'(alu_op), 32'd5);
        chk("stall_alu_a_held",  32'(alu_a),  32'h0F);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Divide and modulus by zero.
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
        send_txn(8'h02, 8'h09, 8'h00, {1'b1, 16'h0000}, 0);
        wait_out_valid(n);
        @(posedge clk); #1;
        send_txn(8'h03, 8'h09, 8'h00, {1'b1, 16'h0000}, 0);
`else
        send_txn(8'h02, 8'h09, 8'h00, {1'b0, 16'hFFFF}, 0);
        wait_out_valid(n);
        @(posedge clk); #1;
        send_txn(8'h03, 8'h09, 8'h00, {1'b0, 16'hFFFF}, 0);
`endif
        wait_out_valid(n);
        @(posedge clk); #1;
        send_txn(8'h02, 8'h09, 8'h02, {1'b0, 16'h0004}, 0);
        wait_out_valid(n);
        @(posedge clk); #1;

        // Reset after A is accepted discards the partial transaction.
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        #3 rst = 1'b0;
        @(posedge clk); #1;
        send_txn(8'h05, 8'hF0, 8'h3C, {1'b0, 16'h0030}, 0);
        wait_out_valid(n);
        @(posedge clk); #1;

        // Randomised gaps and stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            send_txn({4'($urandom), op}, a, b, expect_out(op, a, b), 3);
        end

        rand_ready = 1'b0;
        out_ready  = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
